wb_master_arbiter: RTL
======================

Name: wb_master_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter for the shared 20-bit memory/IO bus.
- Master 0 is the CPU port. Master 1 is a secondary bus master, e.g. a DMA or video fetch engine.
- Grants one master at a time and never switches mid-cycle.
- Limits back-to-back ownership so neither master starves.
- Routes the address, data, control and acknowledge signals of the granted master to and from the slave.

Parameters:
- HOLD_MAX, 4: maximum consecutive acknowledged transfers for one master while the other is requesting. Legal range 1..15.
- PRIO, 0: master that wins a simultaneous request from IDLE when there is no history (after reset). 0 or 1.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m0_adr_i  in  20  master 0 address
- m0_dat_i  in  16  master 0 write data
- m0_dat_o  out  16  master 0 read data
- m0_we_i / m0_mio_i / m0_byte_i / m0_stb_i  in  1 each  master 0 write enable, memory/IO select, byte op, strobe
- m0_ack_o  out  1  master 0 acknowledge
- m1_*  same set as m0_*  master 1
- s_adr_o  out  20  slave address
- s_dat_o  out  16  slave write data
- s_dat_i  in  16  slave read data
- s_we_o / s_mio_o / s_byte_o / s_stb_o  out  1 each  slave controls
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot grant, bit n = master n; 2'b00 when idle.

Behaviour:
- States: IDLE, G0, G1. State register, hold counter (4 bits) and last-owner flag `last` are all cleared asynchronously when rst_i=0.
- Reset values: state=IDLE, cnt=0, last=~PRIO (so PRIO wins first), gnt_o=00. All s_* outputs are 0. m0/m1 ack_o=0 and dat_o=0.
- Output muxing is combinational from the registered state:
  - In Gn, s_adr/dat/we/mio/byte/stb = mn_* and mn_ack_o = s_ack_i.
  - The other master's ack_o = 0.
  - In IDLE, s_stb_o=0 and s_adr/dat/we/mio/byte are forced to 0.
- Read data fan-out: m0_dat_o and m1_dat_o = s_dat_i when that master is granted, else 0.
- Grant latency: a request seen in cycle N from IDLE is granted in cycle N+1. s_stb_o rises in N+1. There is no combinational path from mn_stb_i to gnt_o.
- IDLE transitions:
  - One stb high: go to that master's state.
  - Both high: go to the master != last.
  - cnt cleared on entry to any grant state.
- Gn on s_ack_i=1 (transfer completes):
  - cnt increments (saturates at 15); `last` = n.
  - If the other master's stb=1 and cnt+1 >= HOLD_MAX, switch directly to the other grant state next cycle with cnt=0. No IDLE gap.
  - Otherwise stay in Gn.
- Gn with s_ack_i=0 and mn_stb_i=0 (the master released the bus between cycles):
  - Other master's stb=1: go to the other grant state, cnt=0.
  - Else go to IDLE.
- Gn with mn_stb_i=1 and s_ack_i=0: hold. The grant never changes while a cycle is outstanding, even if HOLD_MAX is already reached.
- A master whose stb is still high after its own ack is treated as issuing a new back-to-back request, counted against HOLD_MAX.
- The ack is never forwarded to a non-granted master. A stray s_ack_i in IDLE is ignored and does not touch cnt.
- Reset mid-transfer: everything returns to IDLE immediately and asynchronously. s_stb_o drops in the same instant. The outstanding slave cycle is abandoned.
- The CPU drives stb high during its reset. Arbitration is suppressed while rst_i=0 and resumes on the first clock edge after release.

Test Plan:
- Reset: hold rst_i=0 with m0_stb_i=1 and m1_stb_i=1 -> gnt_o=00, s_stb_o=0, both ack_o=0. Release with PRIO=0 -> cycle after release gnt_o=01.
- Single master: m1 reads 20'h0B800 with slave ack after 2 wait cycles, s_dat_i=16'hA5C3 -> s_adr_o=20'h0B800 from cycle N+1; m1_ack_o pulses with m1_dat_o=16'hA5C3; m0_ack_o stays 0; then IDLE.
- Hold limit: HOLD_MAX=4, m0 streams with stb held high and 1-cycle acks, m1_stb_i=1 throughout -> exactly 4 m0 acks, then gnt_o=10 on the cycle after the 4th ack with no IDLE gap.
- No preemption: m1 requests while an m0 cycle waits 10 cycles for ack -> gnt_o stays 01 until the ack.
- Handover on release: m0 drops stb with no pending ack while m1 requests -> gnt_o=10 next cycle; s_we_o/s_byte_o follow m1 values (we=1, byte=1).
- Async reset mid-cycle: assert rst_i=0 between clock edges during G1 -> s_stb_o and gnt_o go to 0 before the next edge.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with a hold limit on back-to-back
// ownership. The grant changes only between slave cycles. Address, data,
// control and ack are muxed combinationally from the registered grant state.
module wb_master_arbiter #(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned PRIO     = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [19:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic        m0_mio_i,
  input  logic        m0_byte_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,

  input  logic [19:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic        m1_mio_i,
  input  logic        m1_byte_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,

  output logic [19:0] s_adr_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  output logic        s_we_o,
  output logic        s_mio_o,
  output logic        s_byte_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,

  output logic [1:0]  gnt_o
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W:0]   HOLD_LIM = 5'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = 4'hF;
  localparam logic             PRIO_BIT = PRIO[0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               last;

  logic               own_stb;
  logic               oth_stb;
  logic               own_id;
  state_t             oth_state;
  logic [CNT_W:0]     cnt_p1;
  logic [CNT_W-1:0]   cnt_sat;

  // Helper terms for the granted master: its strobe, the other's, next count
  always_comb begin
    own_stb   = 1'b0;
    oth_stb   = 1'b0;
    own_id    = 1'b0;
    oth_state = IDLE;
    if (state == G0) begin
      own_stb   = m0_stb_i;
      oth_stb   = m1_stb_i;
      own_id    = 1'b0;
      oth_state = G1;
    end else if (state == G1) begin
      own_stb   = m1_stb_i;
      oth_stb   = m0_stb_i;
      own_id    = 1'b1;
      oth_state = G0;
    end
    cnt_p1  = {1'b0, cnt} + 5'd1;
    cnt_sat = (cnt == CNT_SAT) ? CNT_SAT : cnt_p1[CNT_W-1:0];
  end

  // Grant state machine, hold counter and last-owner history
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= ~PRIO_BIT;
    end else begin
      case (state)
        IDLE: begin
          if (m0_stb_i && m1_stb_i) begin
            state <= last ? G0 : G1;
            cnt   <= '0;
          end else if (m0_stb_i) begin
            state <= G0;
            cnt   <= '0;
          end else if (m1_stb_i) begin
            state <= G1;
            cnt   <= '0;
          end
        end
        G0, G1: begin
          if (s_ack_i) begin
            // Transfer completed: count it and hand over once the limit is hit
            last <= own_id;
            if (oth_stb && (cnt_p1 >= HOLD_LIM)) begin
              state <= oth_state;
              cnt   <= '0;
            end else begin
              cnt   <= cnt_sat;
            end
          end else if (!own_stb) begin
            // Owner released the bus between cycles
            if (oth_stb) begin
              state <= oth_state;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Route the granted master to the slave and the slave response back
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_mio_o  = 1'b0;
    s_byte_o = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    case (state)
      G0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_mio_o  = m0_mio_i;
        s_byte_o = m0_byte_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
      G1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_mio_o  = m1_mio_i;
        s_byte_o = m1_byte_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

  assign gnt_o = {state == G1, state == G0};

endmodule
